// File: rtl/rd_score_collect.sv
// Collects per-mode cost records, computes the RD score in a two-stage pipe and
// banks it into one of NUM_MODES slots presented to the argmin selector.
module rd_score_collect #(
   parameter int          NUM_MODES     = 10,
   parameter int          RD_DISTO_MULT = 256,
   parameter logic [63:0] SCORE_MAX     = 64'h7FFF_FFFF_FFFF_FFFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [15:0]        lambda,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_mode,
   input  logic [31:0]        in_d,
   input  logic [31:0]        in_sd,
   input  logic [15:0]        in_r,
   input  logic [15:0]        in_h,
   output logic signed [63:0] score0,
   output logic signed [63:0] score1,
   output logic signed [63:0] score2,
   output logic signed [63:0] score3,
   output logic signed [63:0] score4,
   output logic signed [63:0] score5,
   output logic signed [63:0] score6,
   output logic signed [63:0] score7,
   output logic signed [63:0] score8,
   output logic signed [63:0] score9,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               err
);

   localparam int                   DISTO_SH = $clog2(RD_DISTO_MULT);
   localparam logic [NUM_MODES-1:0] FULL     = '1;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, HOLD} state_t;

   state_t               state_q, state_d;
   logic [15:0]          lambda_q, lambda_d;
   logic [NUM_MODES-1:0] mask_q, mask_d, mode_oh;
   logic                 s1_vld_q, s1_vld_d;
   logic [16:0]          rh_q, rh_d;
   logic [32:0]          dsd_q, dsd_d;
   logic [3:0]           s1_mode_q, s1_mode_d;
   logic                 err_q, err_d;
   logic signed [63:0]   score_q [NUM_MODES];
   logic signed [63:0]   score_d [NUM_MODES];
   logic                 accept, legal, take;
   logic [63:0]          new_score;

   always_comb begin
      in_ready  = (state_q == COLLECT) && (mask_q != FULL);
      accept    = in_valid && in_ready;
      legal     = int'(in_mode) < NUM_MODES;
      mode_oh   = legal ? (NUM_MODES'(1) << in_mode) : '0;
      take      = accept && legal && ((mask_q & mode_oh) == '0);
      // Operands are all unsigned and the sum stays below 2^42, so no saturation.
      new_score = 64'(rh_q) * 64'(lambda_q) + (64'(dsd_q) << DISTO_SH);
   end

   always_comb begin
      state_d   = state_q;
      lambda_d  = lambda_q;
      mask_d    = take ? (mask_q | mode_oh) : mask_q;
      err_d     = accept && !take;
      s1_vld_d  = take;
      rh_d      = {1'b0, in_r} + {1'b0, in_h};
      dsd_d     = {1'b0, in_d} + {1'b0, in_sd};
      s1_mode_d = in_mode;
      score_d   = score_q;
      if (s1_vld_q) score_d[s1_mode_q] = new_score;

      case (state_q)
         IDLE: if (start) begin
            state_d  = COLLECT;
            lambda_d = lambda;
            mask_d   = '0;
            for (int i = 0; i < NUM_MODES; i++) score_d[i] = SCORE_MAX;
         end
         COLLECT: if (mask_d == FULL) state_d = DRAIN;
         // Only stage 1 can still hold a record; stage 2 is the slot write itself.
         DRAIN:   if (!s1_vld_q) state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         lambda_q  <= '0;
         mask_q    <= '0;
         s1_vld_q  <= 1'b0;
         rh_q      <= '0;
         dsd_q     <= '0;
         s1_mode_q <= '0;
         err_q     <= 1'b0;
         for (int i = 0; i < NUM_MODES; i++) score_q[i] <= SCORE_MAX;
      end else begin
         state_q   <= state_d;
         lambda_q  <= lambda_d;
         mask_q    <= mask_d;
         s1_vld_q  <= s1_vld_d;
         rh_q      <= rh_d;
         dsd_q     <= dsd_d;
         s1_mode_q <= s1_mode_d;
         err_q     <= err_d;
         score_q   <= score_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign err       = err_q;

   assign score0 = score_q[0];
   assign score1 = score_q[1];
   assign score2 = score_q[2];
   assign score3 = score_q[3];
   assign score4 = score_q[4];
   assign score5 = score_q[5];
   assign score6 = score_q[6];
   assign score7 = score_q[7];
   assign score8 = score_q[8];
   assign score9 = score_q[9];

endmodule
